mod_updown_counter: RTL and testbench



---
 rtl/mod_updown_counter.sv | 113 +++++++++++
 tb/tb_mod_updown_counter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
// Parametrised modulo up/down counter with enable, clear, load, wrap/saturate
// limits, terminal-count pulse and sticky overflow. Optional prescaler: COUNTER_PRESCALE_EN.
module mod_updown_counter #(
  parameter int          WIDTH    = 7,
  parameter int unsigned MOD_MAX  = 99,
  parameter int          SAT_MODE = 0,
  parameter int          PRESCALE = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD_MAX);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be 2..32");
  end
  if (MOD_MAX < 1 || 64'(MOD_MAX) > ((64'(1) << WIDTH) - 64'(1))) begin : g_bad_max
    $error("mod_updown_counter: MOD_MAX must be 1..2^WIDTH-1");
  end
  if (PRESCALE < 2) begin : g_bad_presc
    $error("mod_updown_counter: PRESCALE must be at least 2");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             tick;

`ifdef COUNTER_PRESCALE_EN
  localparam int            PW         = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;

  // The prescaler only advances on enabled cycles, so gaps in en stretch the step period.
  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q;
    if (clr || load) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      cnt_d = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (en && tick) begin
      if (up_dn) begin
        if (cnt_q != MAX_V) begin
          cnt_d = cnt_q + WIDTH'(1);
        end else begin
          cnt_d = (SAT_MODE != 0) ? MAX_V : '0;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end
      end else begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WIDTH'(1);
        end else begin
          cnt_d = (SAT_MODE != 0) ? '0 : MAX_V;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: wrap, saturate and full-range instances
// share one stimulus set; each step is checked against hand-computed values.
module tb_mod_updown_counter;

`ifdef COUNTER_PRESCALE_EN
  localparam int STEP_CYC = 10;
`else
  localparam int STEP_CYC = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up_dn;
  logic       clr;
  logic       load;
  logic [6:0] load_val;
  logic [3:0] load_val_f;

  logic [6:0] cnt_w;
  logic       tc_w, ovf_w;
  logic [6:0] cnt_s;
  logic       tc_s, ovf_s;
  logic [3:0] cnt_f;
  logic       tc_f, ovf_f;

  int errors = 0;
  int checks = 0;

  assign load_val_f = load_val[3:0];

  mod_updown_counter #(.WIDTH(7), .MOD_MAX(99), .SAT_MODE(0), .PRESCALE(10)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .cnt(cnt_w), .tc(tc_w), .ovf(ovf_w)
  );

  mod_updown_counter #(.WIDTH(7), .MOD_MAX(99), .SAT_MODE(1), .PRESCALE(10)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .cnt(cnt_s), .tc(tc_s), .ovf(ovf_s)
  );

  mod_updown_counter #(.WIDTH(4), .MOD_MAX(15), .SAT_MODE(0), .PRESCALE(10)) u_full (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val_f), .cnt(cnt_f), .tc(tc_f), .ovf(ovf_f)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step();
    edges(STEP_CYC);
  endtask

  task automatic do_load(input logic [6:0] v);
    load     = 1'b1;
    load_val = v;
    edges(1);
    load     = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    #3;
    check("reset_cnt", 32'(cnt_w), 0);
    check("reset_tc", 32'(tc_w), 0);
    check("reset_ovf", 32'(ovf_w), 0);
    edges(2);
    rst_n = 1'b1;
    en    = 1'b1;

    // count up from reset
    step(); check("up_1", 32'(cnt_w), 1);
    step(); check("up_2", 32'(cnt_w), 2);
    step(); check("up_3", 32'(cnt_w), 3);
    repeat (34) step();
    check("up_37", 32'(cnt_w), 37);

    // asynchronous reset mid-count, no clock edge in between
    rst_n = 1'b0;
    #1;
    check("async_rst_cnt", 32'(cnt_w), 0);
    rst_n = 1'b1;
    step(); check("post_rst_1", 32'(cnt_w), 1);

    // up wrap 98 -> 99 -> 0
    do_load(7'd98);
    check("load_98", 32'(cnt_w), 98);
    step(); check("wrap_99", 32'(cnt_w), 99);
    check("wrap_99_tc", 32'(tc_w), 0);
    check("wrap_99_ovf", 32'(ovf_w), 0);
    step(); check("wrap_0", 32'(cnt_w), 0);
    check("wrap_0_tc", 32'(tc_w), 1);
    check("wrap_0_ovf", 32'(ovf_w), 1);
    step(); check("wrap_1", 32'(cnt_w), 1);
    check("wrap_1_tc", 32'(tc_w), 0);
    check("ovf_sticky", 32'(ovf_w), 1);
    clr = 1'b1; edges(1); clr = 1'b0;
    check("clr_cnt", 32'(cnt_w), 0);
    check("clr_ovf", 32'(ovf_w), 0);

    // down wrap 1 -> 0 -> 99
    up_dn = 1'b0;
    do_load(7'd1);
    check("dn_load_1", 32'(cnt_w), 1);
    step(); check("dn_0", 32'(cnt_w), 0);
    check("dn_0_tc", 32'(tc_w), 0);
    step(); check("dn_99", 32'(cnt_w), 99);
    check("dn_99_tc", 32'(tc_w), 1);
    check("dn_99_ovf", 32'(ovf_w), 1);

    // saturate up from 97
    up_dn = 1'b1;
    do_load(7'd97);
    check("sat_load_97", 32'(cnt_s), 97);
    step(); check("sat_98", 32'(cnt_s), 98);
    check("sat_98_tc", 32'(tc_s), 0);
    step(); check("sat_99", 32'(cnt_s), 99);
    check("sat_99_tc", 32'(tc_s), 0);
    step(); check("sat_hold_a", 32'(cnt_s), 99);
    check("sat_hold_a_tc", 32'(tc_s), 1);
    check("sat_hold_a_ovf", 32'(ovf_s), 1);
    step(); check("sat_hold_b", 32'(cnt_s), 99);
    check("sat_hold_b_tc", 32'(tc_s), 1);

    // saturate down from 0
    clr = 1'b1; edges(1); clr = 1'b0;
    check("sat_clr_ovf", 32'(ovf_s), 0);
    up_dn = 1'b0;
    step(); check("sat_dn_0", 32'(cnt_s), 0);
    check("sat_dn_tc", 32'(tc_s), 1);
    check("sat_dn_ovf", 32'(ovf_s), 1);

    // priority and clamp
    up_dn = 1'b1;
    clr = 1'b1; load = 1'b1; load_val = 7'd50;
    edges(1);
    clr = 1'b0; load = 1'b0;
    check("clr_over_load", 32'(cnt_w), 0);
    check("clr_over_load_tc", 32'(tc_s), 0);
    do_load(7'd120);
    check("load_clamp", 32'(cnt_w), 99);
    do_load(7'd40);
    check("load_no_step", 32'(cnt_w), 40);
    en = 1'b0;
    edges(5);
    check("en_low_hold", 32'(cnt_w), 40);
    check("en_low_tc", 32'(tc_w), 0);
    en = 1'b1;

    // full binary range rollover
    do_load(7'd15);
    check("full_load_15", 32'(cnt_f), 15);
    step(); check("full_wrap_0", 32'(cnt_f), 0);
    check("full_wrap_tc", 32'(tc_f), 1);
    up_dn = 1'b0;
    step(); check("full_dn_15", 32'(cnt_f), 15);
    up_dn = 1'b1;

`ifdef COUNTER_PRESCALE_EN
    // prescaler: one step per 10 enabled cycles, paused by en=0
    clr = 1'b1; edges(1); clr = 1'b0;
    edges(9);
    check("presc_9", 32'(cnt_w), 0);
    edges(1);
    check("presc_10", 32'(cnt_w), 1);
    edges(5);
    en = 1'b0;
    edges(3);
    en = 1'b1;
    edges(4);
    check("presc_gap_hold", 32'(cnt_w), 1);
    edges(1);
    check("presc_gap_step", 32'(cnt_w), 2);
`endif

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
